// File: rtl/trng_seed_collector.sv
// Purpose: assembles NWORD entropy words into one W*NWORD-bit seed per request and runs a repetition-count health test.
// Latency: one cycle from an accepted request to COLLECT, then one cycle per accepted word; res_valid rises the cycle after the last word.
// Backpressure: one request at a time (req_ready only in IDLE); a finished seed is held in DONE until res_ready.
//
// Ports:
//   clk, rstn              clock (rising edge) and synchronous active-low reset
//   word_valid, word_in    entropy source; a word is taken on the rising edge of word_valid while collecting
//   req_valid, req_ready   seed request handshake; req_busy is high while words are being collected
//   res_valid, res_ready   seed result handshake; seed carries the first accepted word in its MSBs
//   health_err             one-cycle pulse in the cycle a word completes a run of RCT_LIMIT identical words
//   fail_count             saturating count of health failures since reset
module trng_seed_collector #(
    parameter int W         = 16,
    parameter int NWORD     = 8,
    parameter int RCT_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 word_valid,
    input  logic [W-1:0]         word_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic                 req_busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W*NWORD-1:0]   seed,
    output logic                 health_err,
    output logic [7:0]           fail_count
);

    localparam int SW = W * NWORD;
    localparam int CW = $clog2(NWORD + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            wv_q;        // word_valid history for edge detection
    logic [CW-1:0]   wcnt_q;      // accepted words in the current attempt
    logic [RW-1:0]   rcnt_q;      // length of the current run of identical words
    logic [RW-1:0]   rcnt_nxt;
    logic [W-1:0]    prev_q;      // last accepted word
    logic            prev_vld_q;  // prev_q is meaningful for the repetition test
    logic [SW-1:0]   seed_q;
    logic [7:0]      fail_q;

    logic            accept;
    logic            rct_fail;
    logic            last_word;

    // Only a fresh rising edge of word_valid counts, and only while collecting;
    // edges seen in IDLE/DONE still update wv_q but are otherwise dropped.
    assign accept    = (state_q == COLLECT) && word_valid && !wv_q;
    assign last_word = (wcnt_q == CW'(NWORD - 1));

    always_comb begin
        rcnt_nxt = RW'(1);
        if (prev_vld_q && (word_in == prev_q)) begin
            rcnt_nxt = rcnt_q + RW'(1);
        end
    end

    assign rct_fail = accept && (rcnt_nxt == RW'(RCT_LIMIT));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a health failure on the final word keeps us in COLLECT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && !rct_fail && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign req_busy   = (state_q == COLLECT);
    assign res_valid  = (state_q == DONE);
    assign health_err = rct_fail;
    assign seed       = seed_q;
    assign fail_count = fail_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wv_q       <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            seed_q     <= '0;
            fail_q     <= '0;
        end else begin
            wv_q <= word_valid;
            if ((state_q == IDLE) && req_valid) begin
                wcnt_q     <= '0;
                rcnt_q     <= '0;
                prev_vld_q <= 1'b0;
            end else if (accept) begin
                // Shift form keeps this legal even when NWORD == 1
                seed_q <= (seed_q << W) | SW'(word_in);
                if (rct_fail) begin
                    // Restart the whole collection; the next NWORD words overwrite the seed
                    wcnt_q     <= '0;
                    rcnt_q     <= '0;
                    prev_vld_q <= 1'b0;
                    if (fail_q != 8'hFF) begin
                        fail_q <= fail_q + 8'd1;
                    end
                end else begin
                    wcnt_q     <= wcnt_q + CW'(1);
                    rcnt_q     <= rcnt_nxt;
                    prev_q     <= word_in;
                    prev_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_seed_collector.sv
// Purpose: self-checking bench for trng_seed_collector (directed table plus hand-written corner sequences).
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later, before the next rising edge.
// Backpressure: res_ready is driven directly by the stimulus to exercise holding in DONE.
module tb_trng_seed_collector;

    localparam int W  = 16;
    localparam int NW = 8;
    localparam int SW = W * NW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          word_valid;
    logic [W-1:0]  word_in;
    logic          req_valid;
    logic          req_ready;
    logic          req_busy;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] seed;
    logic          health_err;
    logic [7:0]    fail_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trng_seed_collector #(.W(W), .NWORD(NW), .RCT_LIMIT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .word_valid (word_valid),
        .word_in    (word_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_busy   (req_busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .seed       (seed),
        .health_err (health_err),
        .fail_count (fail_count)
    );

    // One row = one clock cycle: inputs applied for the cycle, outputs expected during it
    typedef struct {
        bit            rstn;
        bit            req;
        bit            wv;
        logic [W-1:0]  word;
        bit            rr;
        bit            chk;
        logic [1:0]    st;
        bit            he;
        logic [7:0]    fc;
        bit            chk_seed;
        logic [SW-1:0] sd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit rq, input bit wv, input logic [W-1:0] w, input bit rr,
                       input bit chk, input logic [1:0] st, input bit he, input logic [7:0] fc,
                       input bit cs, input logic [SW-1:0] sd);
        vec_t v;
        v.rstn = r; v.req = rq; v.wv = wv; v.word = w; v.rr = rr;
        v.chk = chk; v.st = st; v.he = he; v.fc = fc; v.chk_seed = cs; v.sd = sd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] st);
        check({tag, " req_ready"}, SW'(req_ready), SW'(st == S_IDLE));
        check({tag, " req_busy"},  SW'(req_busy),  SW'(st == S_COL));
        check({tag, " res_valid"}, SW'(res_valid), SW'(st == S_DONE));
    endtask

    task automatic drive(input bit r, input bit rq, input bit wv, input logic [W-1:0] w, input bit rr);
        @(negedge clk);
        rstn = r; req_valid = rq; word_valid = wv; word_in = w; res_ready = rr;
        #1;
    endtask

    // Single-cycle pulse on word_valid followed by one low cycle
    task automatic pulse(input logic [W-1:0] w);
        drive(1, 0, 1, w, 0);
        drive(1, 0, 0, '0, 0);
    endtask

    initial begin
        logic [SW-1:0] exp_seed;
        int            exp_fc;

        rstn = 1'b0; req_valid = 1'b0; word_valid = 1'b0; word_in = '0; res_ready = 1'b0;

        // ---- Table: basic seed, handoff, repetition failure then restart ----
        add(0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, '0);
        add(1, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 1, '0);          // reset values
        add(1, 1, 0, 0, 0, 1, S_IDLE, 0, 0, 0, '0);          // request taken at this edge
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 1, W'(i), 0, 1, S_COL, 0, 0, 0, '0);
            add(1, 0, 0, 0, 0, 1, (i == 8) ? S_DONE : S_COL, 0, 0, (i == 8),
                128'h00010002000300040005000600070008);
        end
        add(1, 0, 0, 0, 1, 1, S_DONE, 0, 0, 0, '0);          // consumer takes seed
        add(1, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 1, 128'h00010002000300040005000600070008);
        add(1, 1, 0, 0, 0, 1, S_IDLE, 0, 0, 0, '0);
        for (int i = 1; i <= 4; i++) begin
            add(1, 0, 1, 16'hAAAA, 0, 1, S_COL, (i == 4), 0, 0, '0);
            add(1, 0, 0, 0, 0, 1, S_COL, 0, (i == 4) ? 8'd1 : 8'd0, 0, '0);
        end
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 1, W'(i * 16'h1111), 0, 1, S_COL, 0, 1, 0, '0);
            add(1, 0, 0, 0, 0, 1, (i == 8) ? S_DONE : S_COL, 0, 1, (i == 8),
                128'h11112222333344445555666677778888);
        end
        add(1, 0, 0, 0, 1, 1, S_DONE, 0, 1, 0, '0);
        add(1, 0, 0, 0, 0, 1, S_IDLE, 0, 1, 0, '0);

        foreach (vecs[k]) begin
            drive(vecs[k].rstn, vecs[k].req, vecs[k].wv, vecs[k].word, vecs[k].rr);
            if (vecs[k].chk) begin
                check_state($sformatf("vec%0d", k), vecs[k].st);
                check($sformatf("vec%0d health_err", k), SW'(health_err), SW'(vecs[k].he));
                check($sformatf("vec%0d fail_count", k), SW'(fail_count), SW'(vecs[k].fc));
                if (vecs[k].chk_seed) check($sformatf("vec%0d seed", k), seed, vecs[k].sd);
            end
        end

        // ---- Held-high word_valid is accepted exactly once ----
        drive(1, 1, 0, '0, 0);
        for (int c = 0; c < 20; c++) begin
            drive(1, 0, 1, 16'h1234, 0);
            check("hold health_err", SW'(health_err), '0);
            check_state("hold", S_COL);
        end
        drive(1, 0, 0, '0, 0);
        for (int i = 2; i <= 7; i++) pulse(W'(i));
        check_state("hold after 7 words", S_COL);
        pulse(16'h0008);
        check_state("hold after 8 words", S_DONE);
        exp_seed = 128'h12340002000300040005000600070008;
        check("hold seed", seed, exp_seed);

        // ---- DONE holds the seed and ignores words and requests ----
        for (int c = 0; c < 10; c++) begin
            drive(1, (c >= 8), c[0], 16'h5555, 0);
            check("done seed stable", seed, exp_seed);
            check_state("done hold", S_DONE);
        end
        drive(1, 1, 0, '0, 1);                                // handoff, request still held
        check_state("done handoff", S_DONE);
        drive(1, 1, 0, '0, 0);
        check_state("idle after done", S_IDLE);
        drive(1, 0, 0, '0, 0);
        check_state("held request taken", S_COL);

        // ---- Reset mid-collection discards the partial seed ----
        for (int i = 1; i <= 5; i++) pulse(W'(16'h0100 + i));
        drive(0, 0, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        check_state("reset mid", S_IDLE);
        check("reset seed", seed, '0);
        check("reset fail_count", SW'(fail_count), '0);
        check("reset health_err", SW'(health_err), '0);
        drive(1, 1, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        for (int i = 1; i <= 7; i++) pulse(W'(16'hB000 + i));
        check_state("fresh 7 words", S_COL);
        pulse(16'hB008);
        check_state("fresh 8 words", S_DONE);
        check("fresh seed", seed, 128'hB001B002B003B004B005B006B007B008);
        drive(1, 0, 0, '0, 1);

        // ---- fail_count saturates at 255 ----
        drive(1, 1, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        exp_fc = 0;
        for (int f = 1; f <= 300; f++) begin
            for (int j = 1; j <= 4; j++) begin
                drive(1, 0, 1, 16'h0F0F, 0);
                if (j == 4) check($sformatf("sat health_err %0d", f), SW'(health_err), SW'(1));
                drive(1, 0, 0, '0, 0);
            end
            exp_fc = (f > 255) ? 255 : f;
            check($sformatf("sat fail_count %0d", f), SW'(fail_count), SW'(exp_fc));
        end
        check_state("sat still collecting", S_COL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trng_seed_collector.md
TRNG_SEED_COLLECTOR -- requirements
Module: trng_seed_collector

Interface
REQ-001 SHALL have parameter W, default 16, meaning entropy word width in bits.
REQ-002 SHALL have parameter NWORD, default 8, meaning the number of words per seed, so the seed is W*NWORD = 128 bits.
REQ-003 SHALL have parameter RCT_LIMIT, default 4, meaning the count of consecutive identical words that flags a health failure.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port word_valid, input, 1 bit: the entropy source's word-ready level or pulse.
REQ-007 SHALL have port word_in, input, W bits: the entropy word, sampled when a word is accepted.
REQ-008 SHALL have port req_valid, input, 1 bit: request for a new seed.
REQ-009 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-010 SHALL have port req_busy, output, 1 bit: collection in progress.
REQ-011 SHALL have port res_valid, output, 1 bit: the seed output holds a complete seed.
REQ-012 SHALL have port res_ready, input, 1 bit: consumer has taken the seed.
REQ-013 SHALL have port seed, output, W*NWORD bits: assembled seed.
REQ-014 SHALL have port health_err, output, 1 bit: one-cycle pulse on a repetition-test failure.
REQ-015 SHALL have port fail_count, output, 8 bits: saturating count of health failures since reset.

Function
REQ-016 SHALL implement states IDLE, COLLECT and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE, req_busy 1 only in COLLECT, and res_valid 1 only in DONE, all decoded from state.
REQ-018 In IDLE, req_valid=1 SHALL move to COLLECT on the next edge; the same edge SHALL clear the word counter, repetition counter and previous-word-valid flag.
REQ-019 A word SHALL be accepted only when word_valid=1 in the current cycle and 0 in the previous cycle (rising-edge detect), so a held-high level is accepted once.
REQ-020 The edge detector SHALL track word_valid in every state; an edge in IDLE or DONE SHALL be ignored and SHALL NOT be stored.
REQ-021 On acceptance in COLLECT: seed <= {seed[W*NWORD-W-1:0], word_in}, so the first word ends up in the MSBs; the word counter SHALL increment.
REQ-022 Repetition test: the first word after a request, or after a restart, SHALL set the repeat count to 1.
REQ-023 Repetition test: each later word equal to the previous accepted word SHALL increment the repeat count; a differing word SHALL reset it to 1.
REQ-024 If the repeat count would reach RCT_LIMIT, then in that cycle: health_err=1 for one cycle, fail_count SHALL increment (saturating at 255), and the word counter, repeat count and previous-word-valid flag SHALL clear; the state SHALL stay in COLLECT and collection restarts.
REQ-025 The NWORD-th accepted word without a failure SHALL move the state to DONE on the same edge, so res_valid=1 in the cycle after the last accepted word.
REQ-026 A health failure on the word that would be the NWORD-th SHALL take priority over completion; the state SHALL NOT enter DONE.
REQ-027 In DONE, seed SHALL be held stable; res_valid and res_ready both 1 SHALL return the state to IDLE on that edge.
REQ-028 seed SHALL keep its value in IDLE until the next accepted word.
REQ-029 req_valid asserted in DONE SHALL be ignored (req_ready=0); if still asserted in IDLE, the request SHALL be accepted one cycle after leaving DONE.
REQ-030 res_ready outside DONE SHALL have no effect.
REQ-031 Request-to-result latency SHALL be 1 cycle plus the time to receive NWORD accepted words; no other wait states are allowed.

Reset
REQ-032 With rstn=0 at an edge, the block SHALL enter IDLE with seed=0, req_ready=1, req_busy=0, res_valid=0, health_err=0, fail_count=0, counters cleared, previous-word-valid=0, and the edge-detect history reg=0.
REQ-033 Reset asserted mid-COLLECT or in DONE SHALL discard the partial or complete seed, with the same values as REQ-032 on the next cycle.

Verification
REQ-034 Request, then words 0x0001..0x0008 as single-cycle pulses -> res_valid one cycle after the 8th pulse, seed=0x00010002000300040005000600070008, health_err never 1.
REQ-035 word_valid held high for 20 cycles with word_in=0x1234 during COLLECT -> exactly one word accepted, word counter=1, no health_err.
REQ-036 Words 0xAAAA x4 as pulses after a request -> health_err pulse on the 4th, fail_count=1, counter=0; then 8 distinct words -> seed holds only those 8 words.
REQ-037 In DONE, hold res_ready=0 for 10 cycles while sending word pulses -> seed unchanged, res_valid=1; then res_ready=1 -> IDLE next cycle, req_ready=1.
REQ-038 rstn=0 after 5 of 8 words -> all outputs at reset values next cycle; a new request needs 8 fresh words.
REQ-039 Force 300 failures with repeated words -> fail_count saturates at 255 and never wraps to 0.
